// File: rtl/stream_mem_arbiter.sv
// stream_mem_arbiter: shares one in-order memory stream port among NumReq requesters.
// Define STREAM_MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module stream_mem_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned ReqWidth  = 32,
  parameter int unsigned RespWidth = 32,
  parameter int unsigned MaxTxns   = 4,
  parameter int unsigned IdxWidth  = $clog2(NumReq)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq*ReqWidth-1:0] req_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic [RespWidth-1:0]       resp_o,
  output logic [NumReq-1:0]          resp_valid_o,
  input  logic [NumReq-1:0]          resp_ready_i,
  output logic [ReqWidth-1:0]        mem_req_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  input  logic [RespWidth-1:0]       mem_resp_i,
  input  logic                       mem_resp_valid_i,
  output logic                       mem_resp_ready_o
);

  localparam int unsigned PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

  typedef enum logic {ArbOpen, ArbLocked} arb_state_e;

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] lock_idx_q;
  logic [IdxWidth-1:0] arb_idx;
  logic [IdxWidth-1:0] grant;
  logic [IdxWidth-1:0] head;
  logic                full, push, pop, empty_eff;

  logic [IdxWidth-1:0] fifo_q [MaxTxns];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;

`ifdef STREAM_MEM_ARB_RR_EN
  logic [IdxWidth-1:0] rr_ptr_q;
  logic                found;
  int unsigned         cand;

  // First valid requester at or after the pointer, searching with wrap-around.
  always_comb begin
    arb_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && req_valid_i[cand[IdxWidth-1:0]]) begin
        arb_idx = cand[IdxWidth-1:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (grant == IdxWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
    end
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[i]) arb_idx = IdxWidth'(i);
    end
  end
`endif

  // A locked grant overrides arbitration so the offered request stays stable until accepted.
  always_comb begin
    grant = arb_idx;
    if (rst_i) begin
      grant = '0;
    end else if (state_q == ArbLocked) begin
      grant = lock_idx_q;
    end
  end

  assign full            = (count_q == CntWidth'(MaxTxns));
  assign mem_req_valid_o = (|req_valid_i) & ~full & ~rst_i;
  assign mem_req_o       = req_i[32'(grant) * ReqWidth +: ReqWidth];
  assign push            = mem_req_valid_o & mem_req_ready_i;

  // An empty FIFO falls through to the index being pushed, enabling same-cycle responses.
  assign head      = (count_q == '0) ? grant : fifo_q[rd_ptr_q];
  assign empty_eff = (count_q == '0) & ~push;
  assign resp_o    = mem_resp_i;
  assign pop       = mem_resp_valid_i & mem_resp_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ArbOpen;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= grant;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ArbOpen:   if (mem_req_valid_o && !mem_req_ready_i) state_d = ArbLocked;
      ArbLocked: if (push) state_d = ArbOpen;
      default:   state_d = ArbOpen;
    endcase
  end

  always_comb begin
    req_ready_o      = '0;
    resp_valid_o     = '0;
    mem_resp_ready_o = 1'b0;
    if (!rst_i) begin
      req_ready_o[grant] = mem_req_ready_i & ~full;
      if (!empty_eff) begin
        resp_valid_o[head] = mem_resp_valid_i;
        mem_resp_ready_o   = resp_ready_i[head];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MaxTxns; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxTxns - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxTxns - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  resp_without_txn: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_resp_valid_i && empty_eff));
`endif

endmodule
